// File: rtl/axi_rd_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the two-master AXI read arbiter:
//   - default address/data/ID widths and the derived AR/R payload widths
//   - bit offsets of each field inside the packed AR and R payloads
//     AR = {addr, id, burst[1:0], len[7:0], size[2:0]}
//     R  = {data, id, last, resp[1:0]}
//   - arbiter FSM state encoding
//   - pack helpers for building payloads from individual fields
// -----------------------------------------------------------------------------
package axi_rd_pkg;

  localparam int AXI_AW  = 64;
  localparam int AXI_DW  = 32;
  localparam int AXI_IDW = 4;

  localparam int ARW = AXI_AW + AXI_IDW + 13;
  localparam int RW  = AXI_DW + AXI_IDW + 3;

  // AR field offsets (LSB of each field)
  localparam int AR_SIZE_OFF  = 0;
  localparam int AR_LEN_OFF   = 3;
  localparam int AR_BURST_OFF = 11;
  localparam int AR_ID_OFF    = 13;
  localparam int AR_ADDR_OFF  = 13 + AXI_IDW;

  // R field offsets (LSB of each field); last/resp sit at fixed positions
  // regardless of the configured widths.
  localparam int R_RESP_OFF = 0;
  localparam int R_LAST_OFF = 2;
  localparam int R_ID_OFF   = 3;
  localparam int R_DATA_OFF = 3 + AXI_IDW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic logic [ARW-1:0] ar_pack(input logic [AXI_AW-1:0]  addr,
                                             input logic [AXI_IDW-1:0] id,
                                             input logic [1:0]         burst,
                                             input logic [7:0]         len,
                                             input logic [2:0]         size);
    logic [ARW-1:0] p;
    p = '0;
    p[AR_ADDR_OFF  +: AXI_AW]  = addr;
    p[AR_ID_OFF    +: AXI_IDW] = id;
    p[AR_BURST_OFF +: 2]       = burst;
    p[AR_LEN_OFF   +: 8]       = len;
    p[AR_SIZE_OFF  +: 3]       = size;
    return p;
  endfunction

  function automatic logic [RW-1:0] r_pack(input logic [AXI_DW-1:0]  data,
                                           input logic [AXI_IDW-1:0] id,
                                           input logic               last,
                                           input logic [1:0]         resp);
    logic [RW-1:0] p;
    p = '0;
    p[R_DATA_OFF +: AXI_DW]  = data;
    p[R_ID_OFF   +: AXI_IDW] = id;
    p[R_LAST_OFF]            = last;
    p[R_RESP_OFF +: 2]       = resp;
    return p;
  endfunction

endpackage

// File: rtl/axi_arb_pick.sv
// -----------------------------------------------------------------------------
// axi_arb_pick
// Two-way grant picker. Purely combinational.
// Build option: ARB_RR_EN defined -> round-robin (ptr names the master that
// wins a tie); undefined -> fixed priority, master 0 wins ties, ptr ignored.
// Ports:
//   req  in  2  request per master
//   ptr  in  1  tie-break master (round-robin build only)
//   gnt  out 2  one-hot grant, zero when no request
//   idx  out 1  index of the granted master (0 when no request)
// -----------------------------------------------------------------------------
module axi_arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       idx
);

`ifdef ARB_RR_EN
  assign idx = (req == 2'b11) ? ptr : req[1];
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign idx        = req[1] & ~req[0];
`endif

  assign gnt = {req[1] & idx, req[0] & ~idx};

endmodule

// File: rtl/axi_rd_arb2.sv
// -----------------------------------------------------------------------------
// axi_rd_arb2
// Two-master AXI read-channel arbiter in front of a single read slave.
// One master owns the slave for a whole transaction (AR + complete R burst);
// the AR payload is registered, R beats pass through combinationally to the
// owner. Burst end is taken from R last only. One transaction outstanding.
// Build option: ARB_RR_EN defined -> round-robin, else fixed priority (m0).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   m_arvalid/m_arready   per-master AR handshake (bit i = master i)
//   m_ar                  per-master AR payload, master i at [i*ARW +: ARW]
//   m_rvalid/m_rready     per-master R handshake
//   m_r                   per-master R payload (both lanes carry s_r)
//   s_arvalid/s_arready   slave AR handshake
//   s_ar                  slave AR payload (registered)
//   s_rvalid/s_rready     slave R handshake
//   s_r                   slave R payload
// -----------------------------------------------------------------------------
module axi_rd_arb2
  import axi_rd_pkg::*;
#(
  parameter int AW  = axi_rd_pkg::AXI_AW,
  parameter int DW  = axi_rd_pkg::AXI_DW,
  parameter int IDW = axi_rd_pkg::AXI_IDW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  m_arvalid,
  output logic [1:0]                  m_arready,
  input  logic [2*(AW+IDW+13)-1:0]    m_ar,
  output logic [1:0]                  m_rvalid,
  input  logic [1:0]                  m_rready,
  output logic [2*(DW+IDW+3)-1:0]     m_r,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [AW+IDW+12:0]          s_ar,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [DW+IDW+2:0]           s_r
);

  localparam int AR_W = AW + IDW + 13;

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic [AR_W-1:0]   s_ar_q, s_ar_d;
  logic              ptr;
  logic [1:0]        pick_gnt;
  logic              pick_idx;
  logic [1:0]        m_arready_c;

`ifdef ARB_RR_EN
  logic              ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  axi_arb_pick u_pick (
    .req (m_arvalid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    s_ar_d      = s_ar_q;
`ifdef ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    m_arready_c = 2'b00;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m_rvalid    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Ready is offered only to the picked master, so any grant is a handshake.
        m_arready_c = pick_gnt;
        if (|pick_gnt) begin
          grant_d = pick_idx;
          s_ar_d  = pick_idx ? m_ar[2*AR_W-1:AR_W] : m_ar[AR_W-1:0];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_rready           = m_rready[grant_q];
        m_rvalid[grant_q]  = s_rvalid;
        if (s_rvalid && m_rready[grant_q] && s_r[R_LAST_OFF]) begin
          state_d = ST_IDLE;
`ifdef ARB_RR_EN
          ptr_d   = ~grant_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready must not reach a master while the block is held in reset.
  assign m_arready = m_arready_c & {2{rst_n}};
  assign s_ar      = s_ar_q;
  assign m_r       = {s_r, s_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      s_ar_q  <= '0;
`ifdef ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      s_ar_q  <= s_ar_d;
`ifdef ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arb2
// Directed + randomized bench for axi_rd_arb2. A transaction-level model picks
// the expected winner from the requesting set and a tie-break pointer, and
// predicts per-cycle handshake outputs and payload routing.
// -----------------------------------------------------------------------------
module tb_axi_rd_arb2;
  import axi_rd_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           m_arvalid;
  logic [1:0]           m_arready;
  logic [2*ARW-1:0]     m_ar;
  logic [1:0]           m_rvalid;
  logic [1:0]           m_rready;
  logic [2*RW-1:0]      m_r;
  logic                 s_arvalid;
  logic                 s_arready;
  logic [ARW-1:0]       s_ar;
  logic                 s_rvalid;
  logic                 s_rready;
  logic [RW-1:0]        s_r;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;   // model: master that wins a tie (round-robin build)

  axi_rd_arb2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_ar      (m_ar),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_r       (m_r),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_ar      (s_ar),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_r       (s_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) begin
`ifdef ARB_RR_EN
      return ptr_m;
`else
      return 0;
`endif
    end
    return r[1] ? 1 : 0;
  endfunction

  // One complete read transaction. Requesting masters raise arvalid together;
  // the loser keeps requesting until the transaction ends. abort_beat >= 0
  // pulls rst_n low when that beat is presented.
  task automatic txn(input logic [1:0]  req,
                     input logic [63:0] addr0,
                     input int          len,
                     input int          stall,
                     input int          bp_beat,
                     input int          bp_cyc,
                     input logic [1:0]  last_resp,
                     input int          abort_beat);
    logic [ARW-1:0]  pay [2];
    logic [3:0]      id  [2];
    logic [1:0]      oh;
    logic [RW-1:0]   r;
    int              w, hold, got;
    for (int i = 0; i < 2; i++) begin
      id[i]  = 4'($urandom);
      pay[i] = ar_pack((i == 0) ? addr0 : {$urandom, $urandom}, id[i], 2'b01, 8'(len), 3'b010);
    end
    w  = pick(req);
    oh = (w == 1) ? 2'b10 : 2'b01;
    got = 0;

    // IDLE: grant offered combinationally
    @(negedge clk);
    s_rvalid  = 1'b0;
    s_arready = 1'b0;
    m_rready  = 2'b00;
    m_arvalid = req;
    m_ar      = {pay[1], pay[0]};
    #1;
    chk("idle_s_arvalid", s_arvalid, 0);
    chk("idle_m_rvalid",  m_rvalid,  0);
    chk("idle_m_arready", m_arready, oh);

    // ADDR: s_ar held until the slave accepts
    @(negedge clk);
    m_arvalid[w] = 1'b0;
    for (int c = 0; c <= stall; c++) begin
      if (c > 0) @(negedge clk);
      s_arready = (c == stall);
      #1;
      chk("addr_s_arvalid", s_arvalid, 1);
      chk("addr_s_ar",      s_ar,      pay[w]);
      chk("addr_m_arready", m_arready, 0);
    end

    // DATA
    for (int b = 0; b <= len; b++) begin
      r = r_pack($urandom, id[w], (b == len), (b == len) ? last_resp : 2'b00);
      if (b == 1) begin
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        chk("gap_m_rvalid", m_rvalid, 0);
      end
      hold = (b == bp_beat) ? bp_cyc : 0;
      for (int c = 0; c <= hold; c++) begin
        @(negedge clk);
        if (b == abort_beat) begin
          rst_n    = 1'b0;
          s_rvalid = 1'b1;
          s_r      = r;
          m_rready = 2'b11;
          #1;
          chk("rst_s_arvalid", s_arvalid, 0);
          chk("rst_m_rvalid",  m_rvalid,  0);
          chk("rst_s_rready",  s_rready,  0);
          chk("rst_m_arready", m_arready, 0);
          chk("rst_s_ar",      s_ar,      0);
          @(negedge clk);
          rst_n     = 1'b1;
          s_rvalid  = 1'b0;
          m_rready  = 2'b00;
          m_arvalid = 2'b00;
          ptr_m     = 0;
          return;
        end
        s_rvalid        = 1'b1;
        s_r             = r;
        m_rready[w]     = (c == hold);
        m_rready[1-w]   = 1'($urandom);
        #1;
        chk("data_m_rvalid", m_rvalid, oh);
        chk("data_s_rready", s_rready, (c == hold) ? 1 : 0);
        chk("data_m_r_own",  (w == 1) ? m_r[2*RW-1:RW] : m_r[RW-1:0], r);
        chk("data_m_r_oth",  (w == 1) ? m_r[RW-1:0] : m_r[2*RW-1:RW], r);
        chk("data_m_arready", m_arready, 0);
        if (m_rvalid[w] && m_rready[w]) got++;
      end
    end
    chk("beat_count", got, len + 1);
    ptr_m = 1 - w;
  endtask

  initial begin
    rst_n     = 1'b1;
    m_arvalid = 2'b00;
    m_ar      = '0;
    m_rready  = 2'b00;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_r       = '0;
    #2;
    rst_n     = 1'b0;
    m_arvalid = 2'b11;
    #1;
    chk("reset_m_arready", m_arready, 0);
    chk("reset_s_arvalid", s_arvalid, 0);
    chk("reset_s_ar",      s_ar,      0);
    chk("reset_m_rvalid",  m_rvalid,  0);
    chk("reset_s_rready",  s_rready,  0);
    @(negedge clk);
    m_arvalid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // m0 alone, 4-beat burst
    txn(2'b01, 64'h0000_0000_8000_0000, 3, 0, -1, 0, 2'b00, -1);
    // both requesting: alternation (round-robin) or m0 every time (fixed)
    for (int k = 0; k < 4; k++)
      txn(2'b11, {$urandom, $urandom}, 0, 0, -1, 0, 2'b00, -1);
    // slave AR stall of 5 cycles with the other master waiting
    txn(2'b11, {$urandom, $urandom}, 1, 5, -1, 0, 2'b00, -1);
    // master R backpressure mid-burst
    txn(2'b10, {$urandom, $urandom}, 3, 0, 1, 3, 2'b00, -1);
    // SLVERR on last beat
    txn(2'b01, {$urandom, $urandom}, 2, 0, -1, 0, 2'b10, -1);
    // random mix
    for (int k = 0; k < 8; k++) begin
      int ln;
      ln = $urandom_range(0, 4);
      txn(2'($urandom_range(1, 3)), {$urandom, $urandom}, ln, $urandom_range(0, 2),
          $urandom_range(0, ln), $urandom_range(0, 2), 2'($urandom), -1);
    end
    // reset during beat 2 of 4, then m1 granted normally
    txn(2'b01, {$urandom, $urandom}, 3, 0, -1, 0, 2'b00, 1);
    txn(2'b10, {$urandom, $urandom}, 1, 1, -1, 0, 2'b11, -1);
    txn(2'b11, {$urandom, $urandom}, 0, 0, -1, 0, 2'b00, -1);

    @(negedge clk);
    m_arvalid = 2'b00;
    s_rvalid  = 1'b0;
    #1;
    chk("final_idle_s_arvalid", s_arvalid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
